dm_access_unit: RTL and testbench



---
 rtl/dm_access_unit.sv | 134 +++++++++++++
 tb/tb_dm_access_unit.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_unit.sv
// rtl/dm_access_unit.sv - load/store sequencer in front of data memory dm
// Optional MISALIGN_TRAP_EN: reject misaligned word/half accesses instead of force-aligning them.
module dm_access_unit #(
  parameter int AW = 6,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_type,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [4:0]    req_tag,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic [4:0]    resp_tag,
  output logic          resp_err,
  output logic          dm_wr,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_din,
  output logic [2:0]    dm_type,
  input  logic [31:0]   dm_dout,
  output logic [CW-1:0] acc_cnt,
  output logic [CW-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [2:0] T_WORD  = 3'b000;
  localparam logic [2:0] T_HALF  = 3'b001;
  localparam logic [2:0] T_HALFU = 3'b010;
  localparam logic [2:0] T_BYTEU = 3'b100;
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        state;
  logic          type_err;
  logic          range_err;
  logic          align_err;
  logic          req_err;
  logic          is_half;
  logic [AW-1:0] eff_addr;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Request checks evaluated on the raw request; only used in IDLE at the handshake edge.
  always_comb begin
    is_half   = (req_type == T_HALF) || (req_type == T_HALFU);
    type_err  = (req_type > T_BYTEU) || (req_we && ((req_type == T_HALFU) || (req_type == T_BYTEU)));
    range_err = |req_addr[31:AW];
    align_err = 1'b0;
    eff_addr  = req_addr[AW-1:0];
`ifdef MISALIGN_TRAP_EN
    align_err = ((req_type == T_WORD) && (req_addr[1:0] != 2'b00)) || (is_half && req_addr[0]);
`else
    if (req_type == T_WORD) begin
      eff_addr[1:0] = 2'b00;
    end else if (is_half) begin
      eff_addr[0] = 1'b0;
    end
`endif
    req_err = type_err || range_err || align_err;
  end

  // The dm_* registers double as the latched request; dm_wr alone marks a store in ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_tag   <= 5'd0;
      resp_err   <= 1'b0;
      dm_wr      <= 1'b0;
      dm_addr    <= '0;
      dm_din     <= 32'd0;
      dm_type    <= 3'd0;
      acc_cnt    <= '0;
      err_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            resp_tag  <= req_tag;
            if (req_err) begin
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
              resp_valid <= 1'b1;
              err_cnt    <= sat_inc(err_cnt);
              state      <= RESP;
            end else begin
              resp_err <= 1'b0;
              dm_wr    <= req_we;
              dm_addr  <= eff_addr;
              dm_din   <= req_wdata;
              dm_type  <= req_type;
              state    <= ACCESS;
            end
          end
        end
        ACCESS: begin
          dm_wr      <= 1'b0;
          resp_rdata <= dm_wr ? 32'd0 : dm_dout;
          resp_valid <= 1'b1;
          acc_cnt    <= sat_inc(acc_cnt);
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          dm_wr      <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// tb/tb_dm_access_unit.sv - self-checking bench for dm_access_unit with a behavioural dm
module tb_dm_access_unit;
  localparam int AW  = 6;
  localparam int CW  = 4;
  localparam int SAT = 15;
`ifdef MISALIGN_TRAP_EN
  localparam bit MT = 1'b1;
`else
  localparam bit MT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_tag;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_tag;
  logic        resp_err;
  logic        dm_wr;
  logic [AW-1:0] dm_addr;
  logic [31:0] dm_din;
  logic [2:0]  dm_type;
  logic [31:0] dm_dout;
  logic [CW-1:0] acc_cnt, err_cnt;

  always #5 clk = ~clk;

  dm_access_unit #(.AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_tag(resp_tag), .resp_err(resp_err),
    .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_din(dm_din), .dm_type(dm_type), .dm_dout(dm_dout),
    .acc_cnt(acc_cnt), .err_cnt(err_cnt)
  );

  // Environment: byte-addressed dm, writes on the falling edge, combinational read.
  logic [7:0] mem [0:63];
  logic [5:0] a1, a2, a3;
  assign a1 = dm_addr + 6'd1;
  assign a2 = dm_addr + 6'd2;
  assign a3 = dm_addr + 6'd3;

  always @(negedge clk) begin
    if (dm_wr) begin
      case (dm_type)
        3'b000: begin
          mem[dm_addr] <= dm_din[7:0];  mem[a1] <= dm_din[15:8];
          mem[a2] <= dm_din[23:16];     mem[a3] <= dm_din[31:24];
        end
        3'b001, 3'b010: begin
          mem[dm_addr] <= dm_din[7:0];  mem[a1] <= dm_din[15:8];
        end
        default: mem[dm_addr] <= dm_din[7:0];
      endcase
    end
  end

  always_comb begin
    dm_dout = 32'd0;
    case (dm_type)
      3'b000: dm_dout = {mem[a3], mem[a2], mem[a1], mem[dm_addr]};
      3'b001: dm_dout = {{16{mem[a1][7]}}, mem[a1], mem[dm_addr]};
      3'b010: dm_dout = {16'd0, mem[a1], mem[dm_addr]};
      3'b011: dm_dout = {{24{mem[dm_addr][7]}}, mem[dm_addr]};
      3'b100: dm_dout = {24'd0, mem[dm_addr]};
      default: dm_dout = 32'd0;
    endcase
  end

  // Reference model: byte values as integers, counts of accepted/rejected requests.
  int checks = 0;
  int failures = 0;
  int ref_mem [64];
  int acc_n = 0;
  int err_n = 0;

  function automatic int sat(input int n);
    return (n > SAT) ? SAT : n;
  endfunction

  function automatic bit model_err(input logic we, input int ty, input longint addr);
    bit e;
    e = (ty > 4) || (we && (ty == 2 || ty == 4)) || (addr >= 64);
    if (MT && ((ty == 0 && addr % 4 != 0) || ((ty == 1 || ty == 2) && addr % 2 != 0))) e = 1'b1;
    return e;
  endfunction

  function automatic int eff_addr(input int ty, input longint addr);
    longint a;
    a = addr % 64;
    if (ty == 0) a = a - a % 4;
    else if (ty == 1 || ty == 2) a = a - a % 2;
    return int'(a);
  endfunction

  function automatic int access_size(input int ty);
    return (ty == 0) ? 4 : ((ty == 1 || ty == 2) ? 2 : 1);
  endfunction

  function automatic logic [31:0] model_load(input int ty, input int a);
    longint v;
    v = 0;
    for (int i = access_size(ty) - 1; i >= 0; i--) v = v * 256 + ref_mem[(a + i) % 64];
    if (ty == 1 && v >= 32768) v = v - 65536;
    if (ty == 3 && v >= 128) v = v - 256;
    return v[31:0];
  endfunction

  task automatic model_store(input int ty, input int a, input logic [31:0] wd);
    longint w;
    w = longint'(wd);
    for (int i = 0; i < access_size(ty); i++) begin
      ref_mem[(a + i) % 64] = int'(w % 256);
      w = w / 256;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Called #1 after a rising edge with the unit idle; returns when the unit is idle again.
  task automatic issue(input logic we, input logic [2:0] ty, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] tag, input int hold,
                       output logic [31:0] rd, output logic er,
                       output logic [31:0] exp_rd, output logic exp_er);
    int n;
    int k;
    bit merr;
    int ea;
    merr   = model_err(we, int'(ty), longint'(addr));
    ea     = eff_addr(int'(ty), longint'(addr));
    exp_er = merr;
    exp_rd = (merr || we) ? 32'd0 : model_load(int'(ty), ea);
    req_we = we; req_type = ty; req_addr = addr; req_wdata = wd; req_tag = tag;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!merr) begin
      chk("dm_wr_access", 32'(dm_wr), 32'(we));
      chk("dm_addr_access", 32'(dm_addr), ea);
      chk("dm_din_access", dm_din, wd);
      chk("dm_type_access", 32'(dm_type), 32'(ty));
      if (we) model_store(int'(ty), ea, wd);
      acc_n++;
    end else begin
      chk("dm_wr_rejected", 32'(dm_wr), 32'd0);
      err_n++;
    end
    k = 0;
    while (!resp_valid && k < 20) begin
      @(posedge clk); #1; k++;
    end
    chk("resp_latency", k, merr ? 32'd0 : 32'd1);
    rd = resp_rdata;
    er = resp_err;
    chk("resp_tag", 32'(resp_tag), 32'(tag));
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, rd);
      chk("hold_tag", 32'(resp_tag), 32'(tag));
      chk("hold_err", 32'(resp_err), 32'(er));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("resp_valid_drop", 32'(resp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
    chk("dm_wr_idle", 32'(dm_wr), 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  ty;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  tag;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t vt[$];

  initial begin
    logic [31:0] rd, erd;
    logic er, eer;
    int hs;

    for (int i = 0; i < 64; i++) begin
      mem[i] = 8'd0;
      ref_mem[i] = 0;
    end

    vt.push_back('{1'b1, 3'b000, 32'h08, 32'hDEADBEEF, 5'h01, 32'h0, 1'b0});
    vt.push_back('{1'b0, 3'b000, 32'h08, 32'h0, 5'h02, 32'hDEADBEEF, 1'b0});
    vt.push_back('{1'b1, 3'b011, 32'h03, 32'h12345680, 5'h03, 32'h0, 1'b0});
    vt.push_back('{1'b0, 3'b011, 32'h03, 32'h0, 5'h04, 32'hFFFFFF80, 1'b0});
    vt.push_back('{1'b0, 3'b100, 32'h03, 32'h0, 5'h1F, 32'h00000080, 1'b0});
    vt.push_back('{1'b1, 3'b000, 32'h04, 32'h11223344, 5'h05, 32'h0, 1'b0});
    vt.push_back('{1'b0, 3'b000, 32'h06, 32'h0, 5'h06, MT ? 32'h0 : 32'h11223344, MT});
    vt.push_back('{1'b0, 3'b000, 32'h40, 32'h0, 5'h07, 32'h0, 1'b1});
    vt.push_back('{1'b1, 3'b100, 32'h00, 32'h55, 5'h08, 32'h0, 1'b1});
    vt.push_back('{1'b0, 3'b101, 32'h00, 32'h0, 5'h09, 32'h0, 1'b1});
    vt.push_back('{1'b1, 3'b010, 32'h00, 32'h66, 5'h0A, 32'h0, 1'b1});
    vt.push_back('{1'b1, 3'b001, 32'h0A, 32'hFFFFABCD, 5'h0B, 32'h0, 1'b0});
    vt.push_back('{1'b0, 3'b001, 32'h0A, 32'h0, 5'h0C, 32'hFFFFABCD, 1'b0});
    vt.push_back('{1'b0, 3'b010, 32'h0A, 32'h0, 5'h0D, 32'h0000ABCD, 1'b0});
    vt.push_back('{1'b0, 3'b000, 32'h08, 32'h0, 5'h0E, 32'hABCDBEEF, 1'b0});
    vt.push_back('{1'b1, 3'b001, 32'h0D, 32'h00007777, 5'h0F, 32'h0, MT});
    vt.push_back('{1'b0, 3'b000, 32'h0C, 32'h0, 5'h10, MT ? 32'h0 : 32'h00007777, 1'b0});
    vt.push_back('{1'b0, 3'b011, 32'h3F, 32'h0, 5'h11, 32'h0, 1'b0});
    vt.push_back('{1'b0, 3'b000, 32'h3FFFFFFC, 32'h0, 5'h12, 32'h0, 1'b1});

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_type = 3'd0; req_addr = 32'd0;
    req_wdata = 32'd0; req_tag = 5'd0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_tag", 32'(resp_tag), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_dm_wr", 32'(dm_wr), 32'd0);
    chk("rst_dm_addr", 32'(dm_addr), 32'd0);
    chk("rst_dm_din", dm_din, 32'd0);
    chk("rst_dm_type", 32'(dm_type), 32'd0);
    chk("rst_acc_cnt", 32'(acc_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);

    foreach (vt[i]) begin
      issue(vt[i].we, vt[i].ty, vt[i].addr, vt[i].wd, vt[i].tag, 0, rd, er, erd, eer);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_er));
      chk($sformatf("vec%0d_acc_cnt", i), 32'(acc_cnt), sat(acc_n));
      chk($sformatf("vec%0d_err_cnt", i), 32'(err_cnt), sat(err_n));
    end

    // Backpressure: response held for 5 cycles.
    issue(1'b0, 3'b000, 32'h08, 32'h0, 5'h15, 5, rd, er, erd, eer);
    chk("bp_rdata", rd, 32'hABCDBEEF);
    chk("bp_err", 32'(er), 32'd0);

    // Back-to-back rejected requests with resp_ready held high: one every 2 cycles.
    resp_ready = 1'b1;
    req_we = 1'b0; req_type = 3'b111; req_addr = 32'h0; req_valid = 1'b1;
    hs = 0;
    for (int i = 0; i < 6; i++) begin
      if (req_ready) hs++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    err_n += hs;
    chk("spacing_rejected", hs, 32'd3);
    // Back-to-back successful loads: one every 3 cycles.
    req_type = 3'b000; req_addr = 32'h08; req_valid = 1'b1;
    hs = 0;
    for (int i = 0; i < 6; i++) begin
      if (req_ready) hs++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    resp_ready = 1'b0;
    acc_n += hs;
    chk("spacing_success", hs, 32'd2);
    chk("spacing_acc_cnt", 32'(acc_cnt), sat(acc_n));
    chk("spacing_err_cnt", 32'(err_cnt), sat(err_n));

    // Reset during the ACCESS cycle of a load.
    req_we = 1'b0; req_type = 3'b000; req_addr = 32'h08; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    acc_n = 0; err_n = 0;
    chk("rstmid_resp_valid", 32'(resp_valid), 32'd0);
    chk("rstmid_req_ready", 32'(req_ready), 32'd1);
    chk("rstmid_dm_wr", 32'(dm_wr), 32'd0);
    chk("rstmid_acc_cnt", 32'(acc_cnt), 32'd0);
    @(posedge clk); #1;
    chk("rstmid_no_resp", 32'(resp_valid), 32'd0);

    // Reset during ACCESS of a store: the falling-edge write has already happened.
    req_we = 1'b1; req_type = 3'b000; req_addr = 32'h10; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    model_store(0, 16, 32'hCAFEF00D);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rststore_dm_wr", 32'(dm_wr), 32'd0);
    chk("rststore_resp_valid", 32'(resp_valid), 32'd0);
    issue(1'b0, 3'b000, 32'h10, 32'h0, 5'h1C, 1, rd, er, erd, eer);
    chk("after_rst_rdata", rd, 32'hCAFEF00D);
    chk("after_rst_err", 32'(er), 32'd0);
    chk("after_rst_acc_cnt", 32'(acc_cnt), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 60; i++) begin
      logic        rwe;
      logic [2:0]  rty;
      logic [31:0] raddr;
      rwe   = 1'($urandom % 2);
      rty   = ($urandom % 8 < 6) ? 3'($urandom % 5) : 3'($urandom_range(5, 7));
      raddr = ($urandom % 10 == 0) ? 32'(64 + $urandom % 1000) : 32'($urandom % 64);
      issue(rwe, rty, raddr, $urandom, 5'($urandom), int'($urandom % 3), rd, er, erd, eer);
      chk($sformatf("rand%0d_rdata", i), rd, erd);
      chk($sformatf("rand%0d_err", i), 32'(er), 32'(eer));
    end
    chk("final_acc_cnt", 32'(acc_cnt), sat(acc_n));
    chk("final_err_cnt", 32'(err_cnt), sat(err_n));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
